rx_command_controller: RTL

RX_COMMAND_CONTROLLER -- requirements
Module: rx_command_controller

---
 rtl/rx_command_controller.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/rx_command_controller.sv
// -----------------------------------------------------------------------------
// rx_command_controller
//
// Parses ASCII command frames of the form '#' <1..4 decimal digits> CR coming
// from an 8N1 byte receiver and commits them as a right-aligned BCD value.
// Malformed frames (bad character, too many digits, empty frame, inter-byte
// timeout) are aborted with a one-cycle error pulse and counted.
//
// Ports
//   clock        system clock, all state on its rising edge
//   reset        asynchronous active-low reset
//   rx_valid     one-cycle strobe, rx_byte holds a received byte
//   rx_byte      received byte
//   digits       committed BCD value, least-significant digit in [3:0]
//   digit_count  number of digits in the last committed frame (0..4)
//   frame_valid  one-cycle pulse, a frame was committed
//   frame_error  one-cycle pulse, a frame was aborted
//   busy         high while a frame is in progress or being closed
//   error_count  saturating count of aborted frames
// -----------------------------------------------------------------------------
module rx_command_controller #(
    parameter int MAX_DIGITS     = 4,
    parameter int TIMEOUT_CYCLES = 434000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    rx_valid,
    input  logic [7:0]              rx_byte,
    output logic [4*MAX_DIGITS-1:0] digits,
    output logic [2:0]              digit_count,
    output logic                    frame_valid,
    output logic                    frame_error,
    output logic                    busy,
    output logic [7:0]              error_count
);

    localparam int BUF_W   = 4 * MAX_DIGITS;
    localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]         COUNT_MAX  = 3'(MAX_DIGITS);

    localparam logic [7:0] CHAR_HASH = 8'h23;
    localparam logic [7:0] CHAR_CR   = 8'h0D;
    localparam logic [7:0] CHAR_ZERO = 8'h30;
    localparam logic [7:0] CHAR_NINE = 8'h39;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2,
        ERROR   = 2'd3
    } state_t;

    state_t              state_r, next_state_s;
    logic [BUF_W-1:0]    buffer_r, buffer_next_s;
    logic [2:0]          count_r, count_next_s;
    logic [TIMER_W-1:0]  timer_r, timer_next_s;

    // ASCII '0'..'9'
    function automatic logic is_digit(input logic [7:0] b);
        return (b >= CHAR_ZERO) && (b <= CHAR_NINE);
    endfunction

    // Next-state and frame-buffer update logic
    always_comb begin
        next_state_s  = state_r;
        buffer_next_s = buffer_r;
        count_next_s  = count_r;
        timer_next_s  = timer_r;
        case (state_r)
            IDLE: begin
                if (rx_valid && (rx_byte == CHAR_HASH)) begin
                    next_state_s  = COLLECT;
                    buffer_next_s = '0;
                    count_next_s  = 3'd0;
                    timer_next_s  = '0;
                end else begin
                    next_state_s = IDLE;
                end
            end
            COLLECT: begin
                // A byte arriving in the same cycle wins over the timeout.
                if (rx_valid) begin
                    if (is_digit(rx_byte)) begin
                        if (count_r == COUNT_MAX) begin
                            next_state_s = ERROR;
                        end else begin
                            buffer_next_s = {buffer_r[BUF_W-5:0], 4'(rx_byte - CHAR_ZERO)};
                            count_next_s  = count_r + 3'd1;
                            timer_next_s  = '0;
                        end
                    end else if (rx_byte == CHAR_CR) begin
                        if (count_r == 3'd0) begin
                            next_state_s = ERROR;
                        end else begin
                            next_state_s = DONE;
                        end
                    end else if (rx_byte == CHAR_HASH) begin
                        // Restart the frame without reporting an error.
                        buffer_next_s = '0;
                        count_next_s  = 3'd0;
                        timer_next_s  = '0;
                    end else begin
                        next_state_s = ERROR;
                    end
                end else begin
                    if (timer_r == TIMER_LAST) begin
                        next_state_s = ERROR;
                    end else begin
                        timer_next_s = timer_r + TIMER_W'(1);
                    end
                end
            end
            DONE:    next_state_s = IDLE;
            ERROR:   next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State, frame buffer and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            buffer_r    <= '0;
            count_r     <= 3'd0;
            timer_r     <= '0;
            digits      <= '0;
            digit_count <= 3'd0;
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
            busy        <= 1'b0;
            error_count <= 8'd0;
        end else begin
            state_r     <= next_state_s;
            buffer_r    <= buffer_next_s;
            count_r     <= count_next_s;
            timer_r     <= timer_next_s;
            // Outputs follow the state being entered, so they line up with it.
            frame_valid <= (next_state_s == DONE);
            frame_error <= (next_state_s == ERROR);
            busy        <= (next_state_s != IDLE);
            // Commit on the CR edge so digits appear together with frame_valid.
            if (next_state_s == DONE) begin
                digits      <= buffer_r;
                digit_count <= count_r;
            end
            if ((next_state_s == ERROR) && (error_count != 8'hFF)) begin
                error_count <= error_count + 8'd1;
            end
        end
    end

endmodule
